// File: rtl/icap_pkg.sv
// Shared ICAP write-path types, command constants and the per-byte bit-reversal helper.
// Latency: none (declarations only); backpressure: n/a.
package icap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_STREAM,
    ST_FLUSH,
    ST_WAIT_DONE,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [31:0] ICAP_NOOP    = 32'h2000_0000;
  localparam logic [31:0] ICAP_DUMMY   = 32'hFFFF_FFFF;
  localparam logic        CSIB_ENABLE  = 1'b0;
  localparam logic        CSIB_DISABLE = 1'b1;
  localparam logic        RDWRB_WRITE  = 1'b0;
  localparam logic        RDWRB_READ   = 1'b1;

  // ICAP expects bit 0 of each byte in the MSB position.
  function automatic logic [31:0] bitswap32(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b+i] = w[8*b+7-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_out_reg.sv
// One-deep valid/ready register slice; holds its word until out_rdy_i, clr_i empties it.
// Latency: 1 cycle; backpressure: in_rdy_o = slot empty or draining this cycle.
module icap_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  input  logic         out_rdy_i
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  assign in_rdy_o  = ~vld_q | out_rdy_i;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clr_i) begin
      vld_d = 1'b0;
    end else if (in_vld_i && in_rdy_o) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/icap_write_seq.sv
// Streams a partial bitstream into the ICAP shim with CSIB/RDWRB framing, NOOP flush and PRDONE wait.
// Latency s->m 1 cycle; throttles on icap_avail and m_tready. ICAP_BITSWAP_EN: per-byte bit reversal.
module icap_write_seq
  import icap_pkg::*;
#(
  parameter int unsigned FLUSH_WORDS = 16,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  output logic             csib_out,
  output logic             csib_out_valid,
  output logic             rdwrb_out,
  output logic             rdwrb_out_valid,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  input  logic             icap_avail,
  input  logic             icap_prdone,
  input  logic             icap_prerror,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q;
  logic [31:0]      flush_q;
  logic [31:0]      tmo_q;

  logic        slot_rdy;
  logic        s_hs, flush_hs, flush_left, timeout, start_ok, clr;
  logic        push_vld;
  logic [31:0] push_dat, data_in, noop_w;

`ifdef ICAP_BITSWAP_EN
  assign data_in = bitswap32(s_tdata);
  assign noop_w  = bitswap32(ICAP_NOOP);
`else
  assign data_in = s_tdata;
  assign noop_w  = ICAP_NOOP;
`endif

  assign flush_left = flush_q < FLUSH_WORDS;
  assign timeout    = (TIMEOUT_CYC != 0) && (tmo_q == TIMEOUT_CYC - 1);
  assign s_tready   = (state_q == ST_STREAM) && icap_avail && slot_rdy;
  assign s_hs       = s_tvalid && s_tready;
  assign flush_hs   = (state_q == ST_FLUSH) && flush_left && icap_avail && slot_rdy;
  assign push_vld   = ((state_q == ST_STREAM) && s_tvalid && icap_avail) ||
                      ((state_q == ST_FLUSH) && flush_left && icap_avail);
  assign push_dat   = (state_q == ST_STREAM) ? data_in : noop_w;
  assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  // Entering ERROR discards whatever is parked in the output slice.
  assign clr        = (state_d == ST_ERROR) && (state_q != ST_ERROR);

  icap_out_reg #(.W(32)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .in_vld_i  (push_vld),
    .in_dat_i  (push_dat),
    .in_rdy_o  (slot_rdy),
    .out_vld_o (m_tvalid),
    .out_dat_o (m_tdata),
    .out_rdy_i (m_tready)
  );

  always_comb begin
    state_d         = state_q;
    csib_out        = CSIB_DISABLE;
    rdwrb_out       = RDWRB_READ;
    csib_out_valid  = 1'b1;
    rdwrb_out_valid = 1'b1;
    case (state_q)
      ST_IDLE: begin
        csib_out_valid  = 1'b0;
        rdwrb_out_valid = 1'b0;
        if (start) state_d = ST_ARM;
      end
      ST_ARM: begin
        csib_out  = CSIB_ENABLE;
        rdwrb_out = RDWRB_WRITE;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        csib_out  = CSIB_ENABLE;
        rdwrb_out = RDWRB_WRITE;
        if (icap_prerror)        state_d = ST_ERROR;
        else if (s_hs && s_tlast) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Leave only once the last word has left the slice, so WAIT_DONE never shows m_tvalid.
        csib_out  = CSIB_ENABLE;
        rdwrb_out = RDWRB_WRITE;
        if (icap_prerror)                 state_d = ST_ERROR;
        else if (!flush_left && slot_rdy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        rdwrb_out = RDWRB_WRITE;
        if (icap_prerror || timeout) state_d = ST_ERROR;
        else if (icap_prdone)        state_d = ST_DONE;
      end
      ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      flush_q    <= '0;
      tmo_q      <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok)  word_cnt_q <= '0;
      else if (s_hs) word_cnt_q <= word_cnt_q + CNT_W'(1);
      if (state_q != ST_FLUSH) flush_q <= '0;
      else if (flush_hs)       flush_q <= flush_q + 32'd1;
      if (state_q == ST_WAIT_DONE) tmo_q <= tmo_q + 32'd1;
      else                         tmo_q <= '0;
    end
  end

  assign busy     = (state_q == ST_ARM) || (state_q == ST_STREAM) ||
                    (state_q == ST_FLUSH) || (state_q == ST_WAIT_DONE);
  assign done     = (state_q == ST_DONE);
  assign error    = (state_q == ST_ERROR);
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_icap_write_seq.sv
// Directed bench for icap_write_seq: cycle table for the nominal transfer plus hand sequences.
module tb_icap_write_seq;

  localparam int FW  = 16;
  localparam int TMO = 100;

`ifdef ICAP_BITSWAP_EN
  localparam logic [31:0] NOOP_EXP = 32'h0400_0000;
  localparam logic [31:0] SWAP_EXP = 32'h8040_C020;
`else
  localparam logic [31:0] NOOP_EXP = 32'h2000_0000;
  localparam logic [31:0] SWAP_EXP = 32'h0102_0304;
`endif

  logic        clk = 1'b0;
  logic        rst, start, s_tvalid, s_tready, s_tlast;
  logic [31:0] s_tdata, m_tdata;
  logic        csib_out, csib_out_valid, rdwrb_out, rdwrb_out_valid;
  logic        m_tvalid, m_tready, icap_avail, icap_prdone, icap_prerror;
  logic        busy, done, error;
  logic [31:0] word_cnt;

  always #5 clk = ~clk;

  icap_write_seq #(.FLUSH_WORDS(FW), .TIMEOUT_CYC(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .csib_out(csib_out), .csib_out_valid(csib_out_valid),
    .rdwrb_out(rdwrb_out), .rdwrb_out_valid(rdwrb_out_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .icap_avail(icap_avail), .icap_prdone(icap_prdone), .icap_prerror(icap_prerror),
    .busy(busy), .done(done), .error(error), .word_cnt(word_cnt)
  );

  typedef struct {
    logic        start, svld, slast, prdone;
    logic [31:0] sdat;
    logic        e_srdy, e_mvld;
    logic [31:0] e_mdat;
    logic [2:0]  e_ctl;   // {csib, rdwrb, both valids}
    logic [2:0]  e_bde;   // {busy, done, error}
    logic [31:0] e_cnt;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] src[$];
  logic [31:0] got[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] swz(input logic [31:0] w);
`ifdef ICAP_BITSWAP_EN
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        r[8*b+i] = w[8*b+7-i];
    return r;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] pack_obs(input logic mask_dat);
    return {s_tready, m_tvalid, (mask_dat ? m_tdata : 32'h0), csib_out, rdwrb_out,
            csib_out_valid, rdwrb_out_valid, busy, done, error, word_cnt};
  endfunction

  task automatic addv(input logic st, input logic sv, input logic [31:0] sd, input logic sl,
                      input logic pd, input logic es, input logic em, input logic [31:0] ed,
                      input logic [2:0] ctl, input logic [2:0] bde, input logic [31:0] cnt);
    vec_t v;
    v.start = st; v.svld = sv; v.sdat = sd; v.slast = sl; v.prdone = pd;
    v.e_srdy = es; v.e_mvld = em; v.e_mdat = ed; v.e_ctl = ctl; v.e_bde = bde; v.e_cnt = cnt;
    vq.push_back(v);
  endtask

  // Starts a transfer of src[] and runs it until WAIT_DONE is seen; optionally completes with prdone.
  task automatic run_stream(input string tag, input int lo_at, input int lo_len,
                            input int rdy_pct, input bit finish_done);
    int          n = src.size();
    int          idx = 0, srdy_viol = 0, hold_viol = 0, mism = 0;
    int          budget = n * 6 + 200;
    bit          reached = 0, hold_prev = 0;
    logic [31:0] prev_dat = '0;
    got.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      icap_avail = !(cyc >= lo_at && cyc < lo_at + lo_len);
      if (lo_len > 0 && cyc >= lo_at && cyc < lo_at + 2) m_tready = 1'b0;
      else m_tready = ($urandom_range(99) < rdy_pct);
      if (idx < n) begin
        s_tvalid = 1'b1; s_tdata = src[idx]; s_tlast = (idx == n - 1);
      end else begin
        s_tvalid = 1'b0; s_tlast = 1'b0;
      end
      #1;
      if (cyc == 0) chk({tag, " arm"}, {busy, done, error, csib_out, word_cnt}, {4'b1000, 32'd0});
      if (!icap_avail && s_tready) srdy_viol++;
      if (hold_prev && (!m_tvalid || m_tdata !== prev_dat)) hold_viol++;
      hold_prev = m_tvalid && !m_tready;
      prev_dat  = m_tdata;
      if (m_tvalid && m_tready) got.push_back(m_tdata);
      if (s_tvalid && s_tready) idx++;
      if (busy && csib_out) begin
        reached = 1;
        break;
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1; icap_avail = 1'b1;
    chk({tag, " reach wait_done"}, 80'(reached), 80'd1);
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== ((i < n) ? swz(src[i]) : NOOP_EXP)) mism++;
    chk({tag, " out count"}, 80'(got.size()), 80'(n + FW));
    chk({tag, " out mismatches"}, 80'(mism), 80'd0);
    chk({tag, " word_cnt"}, 80'(word_cnt), 80'(n));
    chk({tag, " s_tready while avail=0"}, 80'(srdy_viol), 80'd0);
    chk({tag, " m_tdata hold"}, 80'(hold_viol), 80'd0);
    if (finish_done) begin
      icap_prdone = 1'b1;
      @(negedge clk); icap_prdone = 1'b0;
      #1;
      chk({tag, " done"}, {busy, done, error, csib_out, m_tvalid}, 5'b01010);
    end
  endtask

  // Presents one word and returns at the negedge after it was accepted.
  task automatic push_word(input logic [31:0] w, input logic last);
    int t = 0;
    s_tvalid = 1'b1; s_tdata = w; s_tlast = last;
    #1;
    while (!s_tready && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk("push handshake", 80'(t < 20), 80'd1);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] W[4];
    int          wcnt;
    W[0] = 32'hAA99_5566; W[1] = 32'h2000_0000; W[2] = 32'h3000_8001; W[3] = 32'h0000_0007;

    rst = 1'b1; start = 0; s_tvalid = 0; s_tdata = '0; s_tlast = 0;
    m_tready = 1; icap_avail = 1; icap_prdone = 0; icap_prerror = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset state", pack_obs(1'b1), {1'b0, 1'b0, 32'h0, 4'b1100, 3'b000, 32'd0});

    // Nominal transfer, one record per cycle: IDLE, ARM, 4 stream cycles, flush, WAIT_DONE, DONE.
    addv(1, 0, 0,    0, 0, 0, 0, 0,            3'b110, 3'b000, 0);
    addv(0, 1, W[0], 0, 0, 0, 0, 0,            3'b001, 3'b100, 0);
    addv(0, 1, W[0], 0, 0, 1, 0, 0,            3'b001, 3'b100, 0);
    addv(1, 1, W[1], 0, 0, 1, 1, swz(W[0]),    3'b001, 3'b100, 1);
    addv(0, 1, W[2], 0, 0, 1, 1, swz(W[1]),    3'b001, 3'b100, 2);
    addv(0, 1, W[3], 1, 0, 1, 1, swz(W[2]),    3'b001, 3'b100, 3);
    addv(0, 0, 0,    0, 0, 0, 1, swz(W[3]),    3'b001, 3'b100, 4);
    for (int k = 0; k < FW; k++)
      addv(0, 0, 0,  0, 0, 0, 1, NOOP_EXP,     3'b001, 3'b100, 4);
    addv(0, 0, 0,    0, 1, 0, 0, 0,            3'b101, 3'b100, 4);
    addv(0, 0, 0,    0, 0, 0, 0, 0,            3'b111, 3'b010, 4);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      start = vq[i].start; s_tvalid = vq[i].svld; s_tdata = vq[i].sdat;
      s_tlast = vq[i].slast; icap_prdone = vq[i].prdone; m_tready = 1; icap_avail = 1;
      #1;
      chk($sformatf("t1 vec%0d", i), pack_obs(vq[i].e_mvld),
          {vq[i].e_srdy, vq[i].e_mvld, (vq[i].e_mvld ? vq[i].e_mdat : 32'h0),
           vq[i].e_ctl[2], vq[i].e_ctl[1], vq[i].e_ctl[0], vq[i].e_ctl[0], vq[i].e_bde, vq[i].e_cnt});
    end
    start = 0; s_tvalid = 0; s_tlast = 0; icap_prdone = 0;

    // Timeout: no prdone, ERROR on the cycle after the 100th WAIT_DONE cycle.
    src.delete(); src.push_back(32'h1234_5678);
    run_stream("t5", 0, 0, 100, 0);
    wcnt = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (error) break;
      if (busy && csib_out) wcnt++;
    end
    chk("t5 wait_done cycles", 80'(wcnt), 80'(TMO));
    chk("t5 error state", {error, busy, m_tvalid, csib_out}, 4'b1001);

    // AVAIL low for 5 cycles mid-stream, shim stalled for the first 2 of them.
    src.delete();
    for (int i = 0; i < 8; i++) src.push_back(32'hC0DE_0000 + 32'(i));
    run_stream("t2", 4, 5, 100, 1);

    // Long transfer with m_tready at 50%.
    src.delete();
    for (int i = 0; i < 1000; i++) src.push_back($urandom);
    run_stream("t3", 0, 0, 50, 1);

    // PRERROR during FLUSH aborts at once; a fresh start recovers.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    push_word(32'h1111_1111, 0);
    push_word(32'h2222_2222, 0);
    push_word(32'h3333_3333, 1);
    @(negedge clk);
    @(negedge clk);
    icap_prerror = 1; s_tvalid = 1; s_tdata = 32'h4444_4444;
    @(negedge clk); icap_prerror = 0;
    #1;
    chk("t4 prerror abort", {error, m_tvalid, s_tready, busy, done}, 5'b10000);
    s_tvalid = 0;
    src.delete(); src.push_back(32'h5555_0001); src.push_back(32'h5555_0002);
    run_stream("t4 restart", 0, 0, 100, 1);

    // Reset mid-STREAM.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    push_word(32'hABCD_0001, 0);
    push_word(32'hABCD_0002, 0);
    chk("t6 pre-reset", {m_tvalid, busy, word_cnt}, {2'b11, 32'd2});
    rst = 1; s_tvalid = 1; s_tdata = 32'hABCD_0003;
    @(negedge clk); #1;
    chk("t6 reset mid-stream", pack_obs(1'b1), {1'b0, 1'b0, 32'h0, 4'b1100, 3'b000, 32'd0});
    rst = 0; s_tvalid = 0;

    // Byte bit-order of the forwarded word.
    src.delete(); src.push_back(32'h0102_0304);
    run_stream("t6 swap", 0, 0, 100, 1);
    chk("t6 swap word", 80'((got.size() > 0) ? got[0] : 32'hDEAD_BEEF), 80'(SWAP_EXP));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
